// File: rtl/online_adder_sequencer.sv
// Control sequencer for an online (MSD-first) adder: walks operand ROM addresses,
// gates and clears the adder, and writes each result vector to RAM after the online delay.
module online_adder_sequencer #(
    parameter int NDIG  = 8,
    parameter int DELTA = 2,
    parameter int NVEC  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [9:0] rom_addr,
    output logic       zero_op,
    output logic       adder_clr,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic [9:0] vec_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0] C_NDIG  = 16'(NDIG);
    localparam logic [15:0] C_ZHI   = 16'(NDIG + 1);
    localparam logic [15:0] C_WLO   = 16'(DELTA + 1);
    localparam logic [15:0] C_WHI   = 16'(NDIG + DELTA);
    localparam logic [15:0] C_TLAST = 16'(NDIG + DELTA);
    localparam logic [9:0]  C_NDIG10 = 10'(NDIG);
    localparam logic [9:0]  C_VLAST  = 10'(NVEC - 1);
    localparam logic [9:0]  C_DOFF   = 10'(DELTA + 1);

    logic [1:0]  r_state;
    logic [15:0] r_t;
    logic [9:0]  r_vec;
    logic [9:0]  r_ram_addr;

    logic        w_run;
    logic [9:0]  w_base;
    logic [9:0]  w_rom_off;
    logic [9:0]  w_waddr;
    logic        w_we;

    assign w_run     = (r_state == S_RUN);
    assign w_base    = r_vec * C_NDIG10;
    assign w_rom_off = (r_t < C_NDIG) ? r_t[9:0] : (C_NDIG10 - 10'd1);
    assign w_waddr   = w_base + r_t[9:0] - C_DOFF;
    // Abort suppresses the write in the very cycle it is seen.
    assign w_we      = w_run && !abort && (r_t >= C_WLO) && (r_t <= C_WHI);

    assign rom_addr  = w_run ? (w_base + w_rom_off) : 10'd0;
    assign zero_op   = !w_run || (r_t == 16'd0) || (r_t >= C_ZHI);
    assign adder_clr = w_run && (r_t == 16'd0);
    assign ram_we    = w_we;
    assign ram_addr  = w_we ? w_waddr : r_ram_addr;
    assign vec_idx   = r_vec;
    assign busy      = w_run;
    assign done      = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_t        <= 16'd0;
            r_vec      <= 10'd0;
            r_ram_addr <= 10'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_t     <= 16'd0;
                        r_vec   <= 10'd0;
                    end
                end
                S_RUN: begin
                    if (w_we) begin
                        r_ram_addr <= w_waddr;
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_t     <= 16'd0;
                    end else if (r_t == C_TLAST) begin
                        r_t <= 16'd0;
                        // Next vector starts immediately, without a gap cycle.
                        if (r_vec < C_VLAST) begin
                            r_vec <= r_vec + 10'd1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_t <= r_t + 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_online_adder_sequencer.sv
// Directed testbench for online_adder_sequencer with NDIG=4, DELTA=2, NVEC=3 (T=7).
// Scenario tasks compare DUT outputs against hand-derived per-cycle expectations.
module tb_online_adder_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] rom_addr;
    logic       zero_op;
    logic       adder_clr;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [9:0] vec_idx;
    logic       busy;
    logic       done;

    int vecCount;
    int missCount;
    int wrCnt[16];
    int clrCnt;
    int doneCnt;

    online_adder_sequencer #(.NDIG(4), .DELTA(2), .NVEC(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .rom_addr(rom_addr),
        .zero_op(zero_op),
        .adder_clr(adder_clr),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .vec_idx(vec_idx),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result RAM and pulse observers, sampled on the same edge the RAM would write on.
    always @(posedge clk) begin
        if (ram_we && (ram_addr < 10'd16)) wrCnt[ram_addr] = wrCnt[ram_addr] + 1;
        if (adder_clr) clrCnt = clrCnt + 1;
        if (done) doneCnt = doneCnt + 1;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        stepCycle();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] got;
        logic [34:0] exp;
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #12;
        got = {rom_addr, ram_addr, vec_idx, ram_we, adder_clr, zero_op, busy, done};
        exp = {10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL reset_values got=%h expected=%h", got, exp);
        end
        #3;
        rst_n = 1'b1;
        repeat (2) stepCycle();
        vecCount++;
        if (busy !== 1'b0 || zero_op !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL idle_after_reset busy=%b zero_op=%b expected busy=0 zero_op=1", busy, zero_op);
        end
    endtask

    task automatic test_full_run();
        int base[16];
        int clrBase;
        int doneBase;
        int v;
        int t;
        int dw;
        int total;
        logic [9:0] expRom;
        logic [9:0] expRa;
        logic [24:0] got;
        logic [24:0] exp;
        for (int i = 0; i < 16; i++) base[i] = wrCnt[i];
        clrBase  = clrCnt;
        doneBase = doneCnt;
        pulseStart();
        for (int k = 0; k < 21; k++) begin
            v = k / 7;
            t = k % 7;
            expRom = 10'(v * 4 + ((t < 4) ? t : 3));
            expRa  = 10'(v * 4 + t - 3);
            got = {busy, done, rom_addr, zero_op, adder_clr, ram_we, vec_idx};
            exp = {1'b1, 1'b0, expRom, (t == 0 || t >= 5), (t == 0), (t >= 3 && t <= 6), 10'(v)};
            vecCount++;
            if (got !== exp) begin
                missCount++;
                $display("[TB] FAIL run_cycle_%0d got=%h expected=%h", k, got, exp);
            end
            if (t >= 3) begin
                vecCount++;
                if (ram_addr !== expRa) begin
                    missCount++;
                    $display("[TB] FAIL ram_addr_cycle_%0d got=%0d expected=%0d", k, ram_addr, expRa);
                end
            end
            // A start pulse mid-run must not restart the sequence.
            start = (k == 10);
            stepCycle();
        end
        start = 1'b0;
        vecCount++;
        if (done !== 1'b1 || busy !== 1'b0 || vec_idx !== 10'd2) begin
            missCount++;
            $display("[TB] FAIL done_pulse done=%b busy=%b vec_idx=%0d expected 1 0 2", done, busy, vec_idx);
        end
        stepCycle();
        vecCount++;
        if (done !== 1'b0 || busy !== 1'b0 || vec_idx !== 10'd2 || zero_op !== 1'b1 || ram_addr !== 10'd11) begin
            missCount++;
            $display("[TB] FAIL idle_after_done done=%b busy=%b vec_idx=%0d zero_op=%b ram_addr=%0d expected 0 0 2 1 11",
                     done, busy, vec_idx, zero_op, ram_addr);
        end
        total = 0;
        for (int a = 0; a < 16; a++) begin
            dw = wrCnt[a] - base[a];
            total += dw;
            vecCount++;
            if (dw !== ((a < 12) ? 1 : 0)) begin
                missCount++;
                $display("[TB] FAIL ram_writes_addr_%0d got=%0d expected=%0d", a, dw, (a < 12) ? 1 : 0);
            end
        end
        vecCount++;
        if (total !== 12) begin
            missCount++;
            $display("[TB] FAIL ram_write_total got=%0d expected=12", total);
        end
        vecCount++;
        if ((clrCnt - clrBase) !== 3 || (doneCnt - doneBase) !== 1) begin
            missCount++;
            $display("[TB] FAIL clr_done_counts clr=%0d done=%0d expected 3 1", clrCnt - clrBase, doneCnt - doneBase);
        end
    endtask

    task automatic test_abort();
        int base[16];
        int doneBase;
        int dw;
        for (int i = 0; i < 16; i++) base[i] = wrCnt[i];
        doneBase = doneCnt;
        pulseStart();
        repeat (11) stepCycle();
        vecCount++;
        if (vec_idx !== 10'd1 || rom_addr !== 10'd7 || ram_we !== 1'b1 || ram_addr !== 10'd5) begin
            missCount++;
            $display("[TB] FAIL abort_position vec_idx=%0d rom_addr=%0d ram_we=%b ram_addr=%0d expected 1 7 1 5",
                     vec_idx, rom_addr, ram_we, ram_addr);
        end
        abort = 1'b1;
        #1;
        vecCount++;
        if (ram_we !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL abort_blocks_write ram_we=%b expected=0", ram_we);
        end
        stepCycle();
        abort = 1'b0;
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || zero_op !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL abort_to_idle busy=%b done=%b ram_we=%b zero_op=%b expected 0 0 0 1",
                     busy, done, ram_we, zero_op);
        end
        repeat (5) stepCycle();
        vecCount++;
        if (busy !== 1'b0 || (doneCnt - doneBase) !== 0) begin
            missCount++;
            $display("[TB] FAIL abort_no_done busy=%b done_pulses=%0d expected 0 0", busy, doneCnt - doneBase);
        end
        for (int a = 0; a < 16; a++) begin
            dw = wrCnt[a] - base[a];
            vecCount++;
            if (dw !== ((a <= 4) ? 1 : 0)) begin
                missCount++;
                $display("[TB] FAIL abort_ram_addr_%0d got=%0d expected=%0d", a, dw, (a <= 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [9:0] expRom;
        applyReset();
        stepCycle();
        start = 1'b1;
        stepCycle();
        for (int k = 0; k < 21; k++) begin
            expRom = 10'((k / 7) * 4 + (((k % 7) < 4) ? (k % 7) : 3));
            vecCount++;
            if (busy !== 1'b1 || vec_idx !== 10'(k / 7) || rom_addr !== expRom) begin
                missCount++;
                $display("[TB] FAIL b2b_cycle_%0d busy=%b vec_idx=%0d rom_addr=%0d expected 1 %0d %0d",
                         k, busy, vec_idx, rom_addr, k / 7, expRom);
            end
            stepCycle();
        end
        vecCount++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_done done=%b busy=%b expected 1 0", done, busy);
        end
        stepCycle();
        vecCount++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_idle_gap done=%b busy=%b expected 0 0", done, busy);
        end
        stepCycle();
        start = 1'b0;
        vecCount++;
        if (busy !== 1'b1 || adder_clr !== 1'b1 || vec_idx !== 10'd0 || rom_addr !== 10'd0) begin
            missCount++;
            $display("[TB] FAIL b2b_restart busy=%b adder_clr=%b vec_idx=%0d rom_addr=%0d expected 1 1 0 0",
                     busy, adder_clr, vec_idx, rom_addr);
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            stepCycle();
            n++;
        end
        vecCount++;
        if (done !== 1'b1 || n !== 21) begin
            missCount++;
            $display("[TB] FAIL b2b_second_run done=%b cycles=%0d expected 1 21", done, n);
        end
        repeat (2) stepCycle();
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_stop busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midrun();
        logic [34:0] got;
        logic [34:0] exp;
        pulseStart();
        repeat (16) stepCycle();
        vecCount++;
        if (vec_idx !== 10'd2 || rom_addr !== 10'd10 || busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL midrun_position vec_idx=%0d rom_addr=%0d busy=%b expected 2 10 1", vec_idx, rom_addr, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {rom_addr, ram_addr, vec_idx, ram_we, adder_clr, zero_op, busy, done};
        exp = {10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL async_reset_midrun got=%h expected=%h", got, exp);
        end
        #2;
        rst_n = 1'b1;
        repeat (4) stepCycle();
        vecCount++;
        if (busy !== 1'b0 || done !== 1'b0 || zero_op !== 1'b1 || vec_idx !== 10'd0) begin
            missCount++;
            $display("[TB] FAIL idle_after_midrun_reset busy=%b done=%b zero_op=%b vec_idx=%0d expected 0 0 1 0",
                     busy, done, zero_op, vec_idx);
        end
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        clrCnt    = 0;
        doneCnt   = 0;
        for (int i = 0; i < 16; i++) wrCnt[i] = 0;
        $display("[TB] starting online_adder_sequencer tests");
        test_reset();
        test_full_run();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
